// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the two SRAM clients and the port arbiter.
// The master side is the requester pair, the slave side is the arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              rq0_valid;
  logic              rq0_ready;
  logic              rq0_we;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic [2:0]        rq0_cfg;

  logic              rq1_valid;
  logic              rq1_ready;
  logic              rq1_we;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic [2:0]        rq1_cfg;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  modport master (
    output rq0_valid, rq0_we, rq0_addr, rq0_wdata, rq0_cfg,
    output rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_cfg,
    input  rq0_ready, rq1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
  );

  modport slave (
    input  rq0_valid, rq0_we, rq0_addr, rq0_wdata, rq0_cfg,
    input  rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_cfg,
    output rq0_ready, rq1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin two-client arbiter/sequencer for a unit_sram_reduced macro, with a
// one-cycle configuration bubble and tagged read-data return.
module sram_port_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int REG_OUT = 0
) (
  input  logic              sram_clk,
  input  logic              sram_rst_n,
  sram_port_arbiter_if.slave rq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_d_in,
  output logic [2:0]        sram_c,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic              sram_reg_out,
  input  logic [DATA_W-1:0] sram_d_out
);
  localparam int TAG_DEPTH = 2 + REG_OUT;

  typedef enum logic {RUN, CFG} state_t;

  state_t               state, state_nxt;
  logic [1:0]           req_valid, req_we;
  logic [ADDR_W-1:0]    req_addr [2];
  logic [DATA_W-1:0]    req_wdata [2];
  logic [2:0]           req_cfg [2];
  logic                 last_grant, lock_pend, locked;
  logic                 win, accept, cfg_load;
  logic [2:0]           cur_cfg;
  logic [TAG_DEPTH-1:0] tag_valid, tag_port;
  logic [1:0]           rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata [2];

  assign req_valid    = {rq.rq1_valid, rq.rq0_valid};
  assign req_we       = {rq.rq1_we, rq.rq0_we};
  assign req_addr[0]  = rq.rq0_addr;
  assign req_addr[1]  = rq.rq1_addr;
  assign req_wdata[0] = rq.rq0_wdata;
  assign req_wdata[1] = rq.rq1_wdata;
  assign req_cfg[0]   = rq.rq0_cfg;
  assign req_cfg[1]   = rq.rq1_cfg;

  assign rq.rq0_ready  = accept & ~win;
  assign rq.rq1_ready  = accept & win;
  assign rq.rsp0_valid = rsp_valid[0];
  assign rq.rsp1_valid = rsp_valid[1];
  assign rq.rsp0_rdata = rsp_rdata[0];
  assign rq.rsp1_rdata = rsp_rdata[1];
  assign sram_reg_out  = (REG_OUT != 0);

  // Right after a bubble the requester that caused it keeps the slot, so the
  // other port cannot steal the configuration it just paid for.
  always_comb begin
    win = 1'b0;
    if (lock_pend && req_valid[locked]) begin
      win = locked;
    end else if (req_valid == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = req_valid[1];
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cfg_load  = 1'b0;
    case (state)
      RUN: begin
        if (req_valid != 2'b00) begin
          if (req_cfg[win] == cur_cfg) begin
            accept = 1'b1;
          end else begin
            cfg_load  = 1'b1;
            state_nxt = CFG;
          end
        end
      end
      CFG: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      state      <= RUN;
      last_grant <= 1'b1;
      lock_pend  <= 1'b0;
      locked     <= 1'b0;
      cur_cfg    <= 3'b000;
    end else begin
      state     <= state_nxt;
      lock_pend <= (state == CFG);
      if (accept) begin
        last_grant <= win;
      end
      if (cfg_load) begin
        locked  <= win;
        cur_cfg <= req_cfg[win];
      end
    end
  end

  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      sram_addr <= '0;
      sram_d_in <= '0;
      sram_c    <= 3'b000;
      sram_wen  <= 1'b0;
      sram_ren  <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      sram_ren <= 1'b0;
      if (accept) begin
        sram_addr <= req_addr[win];
        sram_d_in <= req_wdata[win];
        sram_c    <= req_cfg[win];
        sram_wen  <= req_we[win];
        sram_ren  <= ~req_we[win];
      end else if (cfg_load) begin
        sram_c <= req_cfg[win];
      end
    end
  end

  // The tag tail lines up with the cycle in which the macro presents d_out.
  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      tag_valid    <= '0;
      tag_port     <= '0;
      rsp_valid    <= 2'b00;
      rsp_rdata[0] <= '0;
      rsp_rdata[1] <= '0;
    end else begin
      tag_valid <= {tag_valid[TAG_DEPTH-2:0], accept & ~req_we[win]};
      tag_port  <= {tag_port[TAG_DEPTH-2:0], win};
      rsp_valid <= 2'b00;
      if (tag_valid[TAG_DEPTH-1]) begin
        rsp_valid[tag_port[TAG_DEPTH-1]] <= 1'b1;
        rsp_rdata[tag_port[TAG_DEPTH-1]] <= sram_d_out;
      end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one REG_OUT=0 and one REG_OUT=1 instance share the
// same client stimulus and are compared every cycle against a transaction-level model.
module tb_sram_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    d_valid;
  logic [1:0]    d_we;
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic [2:0]    d_cfg [2];

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.rq0_valid = d_valid[0];
  assign bus0.rq0_we    = d_we[0];
  assign bus0.rq0_addr  = d_addr[0];
  assign bus0.rq0_wdata = d_wdata[0];
  assign bus0.rq0_cfg   = d_cfg[0];
  assign bus0.rq1_valid = d_valid[1];
  assign bus0.rq1_we    = d_we[1];
  assign bus0.rq1_addr  = d_addr[1];
  assign bus0.rq1_wdata = d_wdata[1];
  assign bus0.rq1_cfg   = d_cfg[1];
  assign bus1.rq0_valid = d_valid[0];
  assign bus1.rq0_we    = d_we[0];
  assign bus1.rq0_addr  = d_addr[0];
  assign bus1.rq0_wdata = d_wdata[0];
  assign bus1.rq0_cfg   = d_cfg[0];
  assign bus1.rq1_valid = d_valid[1];
  assign bus1.rq1_we    = d_we[1];
  assign bus1.rq1_addr  = d_addr[1];
  assign bus1.rq1_wdata = d_wdata[1];
  assign bus1.rq1_cfg   = d_cfg[1];

  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_din [2];
  logic [DW-1:0] s_dout [2];
  logic [2:0]    s_c [2];
  logic          s_wen [2];
  logic          s_ren [2];
  logic          s_rego [2];

  logic          rv [2][2];
  logic [DW-1:0] rd [2][2];
  logic          rdy [2][2];
  assign rv[0][0] = bus0.rsp0_valid;  assign rd[0][0] = bus0.rsp0_rdata;
  assign rv[0][1] = bus0.rsp1_valid;  assign rd[0][1] = bus0.rsp1_rdata;
  assign rv[1][0] = bus1.rsp0_valid;  assign rd[1][0] = bus1.rsp0_rdata;
  assign rv[1][1] = bus1.rsp1_valid;  assign rd[1][1] = bus1.rsp1_rdata;
  assign rdy[0][0] = bus0.rq0_ready;  assign rdy[0][1] = bus0.rq1_ready;
  assign rdy[1][0] = bus1.rq0_ready;  assign rdy[1][1] = bus1.rq1_ready;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REG_OUT(0)) dut0 (
    .sram_clk(clk), .sram_rst_n(rst_n), .rq(bus0.slave),
    .sram_addr(s_addr[0]), .sram_d_in(s_din[0]), .sram_c(s_c[0]),
    .sram_wen(s_wen[0]), .sram_ren(s_ren[0]), .sram_reg_out(s_rego[0]),
    .sram_d_out(s_dout[0])
  );

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REG_OUT(1)) dut1 (
    .sram_clk(clk), .sram_rst_n(rst_n), .rq(bus1.slave),
    .sram_addr(s_addr[1]), .sram_d_in(s_din[1]), .sram_c(s_c[1]),
    .sram_wen(s_wen[1]), .sram_ren(s_ren[1]), .sram_reg_out(s_rego[1]),
    .sram_d_out(s_dout[1])
  );

  // Stand-in macros: 16-word synchronous RAM, second instance has the extra output register
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mac_mem [2][16];
  logic [DW-1:0] mac_q [2];
  logic [DW-1:0] mac_q2 [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!mem_ready) begin
        for (int i = 0; i < 16; i++) mac_mem[k][i] <= '0;
        mac_q[k]  <= '0;
        mac_q2[k] <= '0;
      end else begin
        if (s_ren[k]) mac_q[k] <= mac_mem[k][s_addr[k][3:0]];
        if (s_wen[k]) mac_mem[k][s_addr[k][3:0]] <= s_din[k];
        mac_q2[k] <= mac_q[k];
      end
    end
  end
  assign s_dout[0] = mac_q[0];
  assign s_dout[1] = mac_q2[1];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Transaction-level reference state
  typedef struct { int due; bit port; logic [DW-1:0] data; } rsp_t;
  rsp_t          q0[$];
  rsp_t          q1[$];
  logic [DW-1:0] m_mem [16];
  logic [2:0]    m_cfg;
  bit            m_in_cfg, m_lock_pend, m_locked, m_last;
  bit            m_acc, m_bub, m_win;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [2:0]    e_c;
  bit            e_wen, e_ren;
  bit            e_rv [2][2];
  logic [DW-1:0] e_rd [2][2];
  bit            held [2];
  bit            last_rdy [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_cfg = 3'b000; m_in_cfg = 0; m_lock_pend = 0; m_locked = 0; m_last = 1;
    m_acc = 0; m_bub = 0; m_win = 0;
    e_addr = '0; e_din = '0; e_c = 3'b000; e_wen = 0; e_ren = 0;
    for (int k = 0; k < 2; k++) begin
      held[k] = 0;
      for (int p = 0; p < 2; p++) begin
        e_rv[k][p] = 0;
        e_rd[k][p] = '0;
      end
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic modelDecide();
    m_acc = 0; m_bub = 0; m_win = 0;
    if (!m_in_cfg && d_valid != 2'b00) begin
      if (m_lock_pend && d_valid[m_locked]) m_win = m_locked;
      else if (d_valid == 2'b11)           m_win = !m_last;
      else                                  m_win = d_valid[1];
      if (d_cfg[m_win] == m_cfg) m_acc = 1;
      else                       m_bub = 1;
    end
  endtask

  task automatic modelEdge();
    rsp_t r;
    cyc++;
    e_wen = 0;
    e_ren = 0;
    if (m_acc) begin
      e_addr = d_addr[m_win];
      e_din  = d_wdata[m_win];
      e_c    = d_cfg[m_win];
      e_wen  = d_we[m_win];
      e_ren  = !d_we[m_win];
      m_last = m_win;
      if (d_we[m_win]) begin
        m_mem[d_addr[m_win][3:0]] = d_wdata[m_win];
      end else begin
        r.port = m_win;
        r.data = m_mem[d_addr[m_win][3:0]];
        r.due  = cyc + 2;
        q0.push_back(r);
        r.due  = cyc + 3;
        q1.push_back(r);
      end
    end else if (m_bub) begin
      e_c      = d_cfg[m_win];
      m_cfg    = d_cfg[m_win];
      m_locked = m_win;
    end
    m_lock_pend = m_in_cfg;
    m_in_cfg    = m_bub;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) e_rv[k][p] = 0;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      r = q0.pop_front();
      e_rv[0][r.port] = 1;
      e_rd[0][r.port] = r.data;
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      r = q1.pop_front();
      e_rv[1][r.port] = 1;
      e_rd[1][r.port] = r.data;
    end
    for (int p = 0; p < 2; p++) held[p] = d_valid[p] && !(m_acc && m_win == p);
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d sram_addr", k), 64'(s_addr[k]), 64'(e_addr));
      chk($sformatf("dut%0d sram_d_in", k), 64'(s_din[k]), 64'(e_din));
      chk($sformatf("dut%0d sram_c", k), 64'(s_c[k]), 64'(e_c));
      chk($sformatf("dut%0d sram_wen", k), 64'(s_wen[k]), 64'(e_wen));
      chk($sformatf("dut%0d sram_ren", k), 64'(s_ren[k]), 64'(e_ren));
      chk($sformatf("dut%0d sram_reg_out", k), 64'(s_rego[k]), 64'(k == 1));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("dut%0d rsp%0d_valid", k, p), 64'(rv[k][p]), 64'(e_rv[k][p]));
        chk($sformatf("dut%0d rsp%0d_rdata", k, p), 64'(rd[k][p]), 64'(e_rd[k][p]));
      end
    end
  endtask

  // One clock: settle inputs, check ready, step the model at the edge, check registered outputs
  task automatic tick();
    #1;
    modelDecide();
    last_rdy[0] = rdy[0][0];
    last_rdy[1] = rdy[0][1];
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d rq0_ready", k), 64'(rdy[k][0]), 64'(m_acc && !m_win));
      chk($sformatf("dut%0d rq1_ready", k), 64'(rdy[k][1]), 64'(m_acc && m_win));
    end
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic setReq(input int p, input bit v, input bit we, input int addr,
                        input logic [DW-1:0] data, input logic [2:0] cfg);
    d_valid[p] = v;
    d_we[p]    = we;
    d_addr[p]  = AW'(addr);
    d_wdata[p] = data;
    d_cfg[p]   = cfg;
  endtask

  task automatic issue(input int p, input bit we, input int addr,
                       input logic [DW-1:0] data, input logic [2:0] cfg);
    bit got = 0;
    setReq(p, 1'b1, we, addr, data, cfg);
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = last_rdy[p];
    end
    chk("issue accepted within budget", 64'(got), 64'(1));
    d_valid[p] = 1'b0;
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < 2; p++) begin
      if (held[p]) begin
        if ($urandom_range(0, 7) == 0) d_valid[p] = 1'b0;
      end else begin
        d_valid[p] = ($urandom_range(0, 99) < 70);
        d_we[p]    = 1'($urandom_range(0, 1));
        d_addr[p]  = AW'($urandom_range(0, 7));
        d_wdata[p] = $urandom;
        d_cfg[p]   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : m_cfg;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) setReq(p, 1'b0, 1'b0, 0, '0, 3'b000);
    modelReset();
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    checkOutput();
    rst_n = 1'b1;

    // Write then read back on port 0
    issue(0, 1'b1, 0, 32'h0005FFAB, 3'b000);
    chk("t1 wen asserted", 64'(s_wen[0]), 64'(1));
    setReq(0, 1'b1, 1'b0, 0, '0, 3'b000);
    tick();
    chk("t1 read accepted", 64'(last_rdy[0]), 64'(1));
    chk("t1 wen single cycle", 64'(s_wen[0]), 64'(0));
    d_valid[0] = 1'b0;
    tick();
    chk("t1 rsp0 not early", 64'(bus0.rsp0_valid), 64'(0));
    tick();
    chk("t1 rsp0 valid", 64'(bus0.rsp0_valid), 64'(1));
    chk("t1 rsp0 data", 64'(bus0.rsp0_rdata), 64'h0005FFAB);
    chk("t1 rsp1 quiet", 64'(bus0.rsp1_valid), 64'(0));
    tick();
    chk("t1 reg_out rsp0 valid", 64'(bus1.rsp0_valid), 64'(1));
    chk("t1 reg_out rsp0 data", 64'(bus1.rsp0_rdata), 64'h0005FFAB);

    // Reset with a read in flight
    setReq(0, 1'b1, 1'b0, 0, '0, 3'b000);
    tick();
    d_valid[0] = 1'b0;
    chk("t5 ren before reset", 64'(s_ren[0]), 64'(1));
    rst_n = 1'b0;
    modelReset();
    #1;
    chk("t5 ren cleared", 64'(s_ren[0]), 64'(0));
    chk("t5 rdata cleared", 64'(bus0.rsp0_rdata), 64'(0));
    checkOutput();
    repeat (2) begin
      @(negedge clk);
      checkOutput();
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin
      tick();
      pulses += int'(bus0.rsp0_valid) + int'(bus0.rsp1_valid) + int'(bus1.rsp0_valid) + int'(bus1.rsp1_valid);
    end
    chk("t5 no response after reset", 64'(pulses), 64'(0));
    chk("t5 sram_c after reset", 64'(s_c[0]), 64'(0));

    // Both ports read every cycle: strict alternation starting at port 0
    setReq(0, 1'b1, 1'b0, 4, '0, 3'b000);
    setReq(1, 1'b1, 1'b0, 5, '0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2 grant port0", 64'(last_rdy[0]), 64'(i % 2 == 0));
      chk("t2 grant port1", 64'(last_rdy[1]), 64'(i % 2 == 1));
    end
    d_valid = 2'b00;
    repeat (4) tick();

    // Config change on port 1 with port 0 trying to steal the slot
    setReq(1, 1'b1, 1'b1, 2, 32'h000000B2, 3'b010);
    tick();
    chk("t3 no ready on mismatch", 64'(last_rdy[1]), 64'(0));
    chk("t3 sram_c in bubble", 64'(s_c[0]), 64'(3'b010));
    chk("t3 no strobe in bubble", 64'({s_wen[0], s_ren[0]}), 64'(0));
    setReq(0, 1'b1, 1'b0, 1, '0, 3'b000);
    tick();
    chk("t3 bubble ready0", 64'(last_rdy[0]), 64'(0));
    chk("t3 bubble ready1", 64'(last_rdy[1]), 64'(0));
    tick();
    chk("t3 locked port1 wins", 64'(last_rdy[1]), 64'(1));
    chk("t3 port0 blocked", 64'(last_rdy[0]), 64'(0));
    d_valid[1] = 1'b0;
    chk("t3 wen", 64'(s_wen[0]), 64'(1));
    chk("t3 addr", 64'(s_addr[0]), 64'(2));
    chk("t3 d_in", 64'(s_din[0]), 64'h000000B2);
    repeat (3) tick();
    chk("t3 port0 after its own bubble", 64'(last_rdy[0]), 64'(1));
    d_valid[0] = 1'b0;

    // Back-to-back reads through the REG_OUT=1 instance
    issue(0, 1'b1, 1, 32'h000000A1, 3'b000);
    setReq(0, 1'b1, 1'b0, 0, '0, 3'b000);
    tick();
    chk("t4 first read accepted", 64'(last_rdy[0]), 64'(1));
    setReq(0, 1'b1, 1'b0, 1, '0, 3'b000);
    tick();
    chk("t4 second read accepted", 64'(last_rdy[0]), 64'(1));
    d_valid[0] = 1'b0;
    chk("t4 reg_out pin", 64'(s_rego[1]), 64'(1));
    tick();
    chk("t4 not yet valid", 64'(bus1.rsp0_valid), 64'(0));
    tick();
    chk("t4 first rsp valid", 64'(bus1.rsp0_valid), 64'(1));
    chk("t4 first rsp data", 64'(bus1.rsp0_rdata), 64'h0005FFAB);
    tick();
    chk("t4 second rsp valid", 64'(bus1.rsp0_valid), 64'(1));
    chk("t4 second rsp data", 64'(bus1.rsp0_rdata), 64'h000000A1);
    tick();
    chk("t4 pulse ends", 64'(bus1.rsp0_valid), 64'(0));

    // Idle stretch leaves the pointer and configuration alone
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6 idle strobes", 64'({s_wen[0], s_ren[0], s_wen[1], s_ren[1]}), 64'(0));
    end
    chk("t6 sram_c kept", 64'(s_c[0]), 64'(0));
    setReq(0, 1'b1, 1'b0, 3, '0, 3'b000);
    setReq(1, 1'b1, 1'b0, 6, '0, 3'b000);
    tick();
    chk("t6 pointer kept", 64'(last_rdy[1]), 64'(1));
    d_valid[1] = 1'b0;
    tick();
    d_valid[0] = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      tick();
    end
    d_valid = 2'b00;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
